// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C initiator (START, addr+R/W, data, ACKs, STOP).
// Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock stretching on scl_in.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wdata,
  output logic       wreq,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WR,
    S_WACK, S_RD, S_MACK, S_STOP
  } state_t;

  state_t        r_st;
  logic [1:0]    r_q;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [3:0]    r_left;
  logic [7:0]    r_sh;
  logic [6:0]    r_rx;
  logic          r_rw;
  logic          r_scl, r_sda;
  logic          r_busy, r_done, r_wreq, r_rvalid, r_ack_err;
  logic [7:0]    r_rdata;
  logic          r_sda_s1, r_sda_s2;

  logic w_hold, w_tick, w_samp, w_more, w_wbit, w_drv, w_accept;

  // two-flop synchroniser for the SDA pad
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_MASTER_CLK_STRETCH_EN
  logic r_scl_s1, r_scl_s2;

  // synchronise SCL so a slave holding it low freezes the quarter timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
    end
  end

  assign w_hold = !r_scl && !r_scl_s2;
`else
  logic w_unused;
  assign w_unused = scl_in;
  assign w_hold   = 1'b0;
`endif

  assign w_tick   = r_busy && !w_hold && (r_cnt == LAST);
  assign w_samp   = r_sda_s2;
  assign w_more   = (r_left > 4'd1);
  assign w_wbit   = (r_bit == 3'd7) ? wdata[7] : r_sh[7];
  assign w_accept = start && !r_busy && !r_done;

  // SDA pull-down wanted at the first quarter of the current bit
  always_comb begin
    w_drv = 1'b0;
    unique case (r_st)
      S_ADDR:  w_drv = !r_sh[7];
      S_WR:    w_drv = !w_wbit;
      S_MACK:  w_drv = w_more;
      default: w_drv = 1'b0;
    endcase
  end

  // quarter timer, bus sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_st      <= S_IDLE;
      r_q       <= 2'd0;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_left    <= 4'd0;
      r_sh      <= 8'd0;
      r_rx      <= 7'd0;
      r_rw      <= 1'b0;
      r_scl     <= 1'b0;
      r_sda     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wreq    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'd0;
    end else begin
      r_done   <= 1'b0;
      r_wreq   <= 1'b0;
      r_rvalid <= 1'b0;
      if (r_busy && !w_hold)
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_st      <= S_START;
        r_q       <= 2'd0;
        r_cnt     <= '0;
        r_sh      <= {addr, rw};
        r_rw      <= rw;
        r_bit     <= 3'd7;
        r_left    <= (len == 4'd0) ? 4'd1 : len;
        r_ack_err <= 1'b0;
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        unique case (r_st)
          S_START: begin
            if (r_q == 2'd0) begin
              r_sda <= 1'b1;
            end else begin
              r_scl <= 1'b1;
              r_st  <= S_ADDR;
              r_q   <= 2'd0;
            end
          end
          S_STOP: begin
            unique case (r_q)
              2'd0: begin
                r_scl <= 1'b1;
                r_sda <= 1'b1;
              end
              2'd1: r_scl <= 1'b0;
              2'd2: r_sda <= 1'b0;
              2'd3: begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_st   <= S_IDLE;
                r_cnt  <= '0;
              end
            endcase
          end
          S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK: begin
            unique case (r_q)
              2'd0: begin
                r_scl <= 1'b1;
                r_sda <= w_drv;
                if (r_st == S_WR && r_bit == 3'd7)
                  r_sh <= wdata;
              end
              2'd1: r_scl <= 1'b1;
              2'd2: r_scl <= 1'b0;
              2'd3: begin
                unique case (r_st)
                  S_ADDR, S_WR: begin
                    if (r_bit == 3'd0) begin
                      r_st <= (r_st == S_ADDR) ? S_AACK : S_WACK;
                    end else begin
                      r_bit <= r_bit - 3'd1;
                      r_sh  <= {r_sh[6:0], 1'b0};
                    end
                  end
                  S_AACK: begin
                    r_bit <= 3'd7;
                    if (w_samp) begin
                      r_ack_err <= 1'b1;
                      r_st      <= S_STOP;
                    end else begin
                      r_st <= r_rw ? S_RD : S_WR;
                    end
                  end
                  S_WACK: begin
                    r_bit <= 3'd7;
                    if (w_samp) begin
                      r_ack_err <= 1'b1;
                      r_st      <= S_STOP;
                    end else if (w_more) begin
                      r_left <= r_left - 4'd1;
                      r_wreq <= 1'b1;
                      r_st   <= S_WR;
                    end else begin
                      r_st <= S_STOP;
                    end
                  end
                  S_RD: begin
                    r_rx <= {r_rx[5:0], w_samp};
                    if (r_bit == 3'd0) begin
                      r_rdata  <= {r_rx, w_samp};
                      r_rvalid <= 1'b1;
                      r_st     <= S_MACK;
                    end else begin
                      r_bit <= r_bit - 3'd1;
                    end
                  end
                  default: begin
                    r_bit <= 3'd7;
                    if (w_more) begin
                      r_left <= r_left - 4'd1;
                      r_st   <= S_RD;
                    end else begin
                      r_st <= S_STOP;
                    end
                  end
                endcase
              end
            endcase
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  assign wreq    = r_wreq;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign scl_oe  = r_scl;
  assign sda_oe  = r_sda;

endmodule
